// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two issue lanes.
// A winner's command is held in registers for EXEC_CYCLES cycles, and then {Y1,Y2} is returned tagged with its ID.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [10:0]  req0_cmd,
    input  logic [127:0] req0_opnd,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [10:0]  req1_cmd,
    input  logic [127:0] req1_opnd,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [63:0]  rsp_y,

    output logic [2:0]   alu_op,
    output logic         alu_form,
    output logic [1:0]   alu_vec,
    output logic [31:0]  alu_a,
    output logic [31:0]  alu_b,
    output logic [31:0]  alu_c,
    output logic [31:0]  alu_d,
    output logic         alu_copy_neg,
    output logic [3:0]   alu_copy_select,
    input  logic [31:0]  alu_y1,
    input  logic [31:0]  alu_y2,

    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic          last_grant;
    logic          grant;
    logic          accept;
    logic          cur_id;
    logic [3:0]    exec_cnt;
    logic [10:0]   sel_cmd;
    logic [127:0]  sel_opnd;

    // On a tie, the requester that did not win last time goes next.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    assign sel_cmd  = grant ? req1_cmd  : req0_cmd;
    assign sel_opnd = grant ? req1_opnd : req0_opnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)          state_nxt = EXEC;
            EXEC: if (exec_cnt == '0)  state_nxt = RESP;
            RESP: if (rsp_ready)       state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op          <= '0;
            alu_form        <= 1'b0;
            alu_vec         <= '0;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_c           <= '0;
            alu_d           <= '0;
            alu_copy_neg    <= 1'b0;
            alu_copy_select <= '0;
            rsp_valid       <= 1'b0;
            rsp_id          <= 1'b0;
            rsp_y           <= '0;
            exec_cnt        <= '0;
            cur_id          <= 1'b0;
            last_grant      <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_op          <= sel_cmd[10:8];
                        alu_form        <= sel_cmd[7];
                        alu_vec         <= sel_cmd[6:5];
                        alu_copy_neg    <= sel_cmd[4];
                        alu_copy_select <= sel_cmd[3:0];
                        alu_a           <= sel_opnd[127:96];
                        alu_b           <= sel_opnd[95:64];
                        alu_c           <= sel_opnd[63:32];
                        alu_d           <= sel_opnd[31:0];
                        cur_id          <= grant;
                        last_grant      <= grant;
                        exec_cnt        <= EXEC_LAST;
                    end
                end
                EXEC: begin
                    if (exec_cnt == '0) begin
                        rsp_y     <= {alu_y1, alu_y2};
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with EXEC_CYCLES=1 and one with EXEC_CYCLES=3.
// A small ALU stand-in computes Y1/Y2 from the registered alu_* outputs.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A (EXEC_CYCLES = 1)
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [10:0]  req0_cmd, req1_cmd;
    logic [127:0] req0_opnd, req1_opnd;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [63:0]  rsp_y;
    logic [2:0]   alu_op;
    logic         alu_form, alu_copy_neg;
    logic [1:0]   alu_vec;
    logic [31:0]  alu_a, alu_b, alu_c, alu_d, alu_y1, alu_y2;
    logic [3:0]   alu_copy_select;

    // Instance B (EXEC_CYCLES = 3)
    logic         b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
    logic [10:0]  b_req0_cmd, b_req1_cmd;
    logic [127:0] b_req0_opnd, b_req1_opnd;
    logic         b_rsp_valid, b_rsp_ready, b_rsp_id, b_busy;
    logic [63:0]  b_rsp_y;
    logic [2:0]   b_alu_op;
    logic         b_alu_form, b_alu_copy_neg;
    logic [1:0]   b_alu_vec;
    logic [31:0]  b_alu_a, b_alu_b, b_alu_c, b_alu_d, b_alu_y1, b_alu_y2;
    logic [3:0]   b_alu_copy_select;

    alu_arbiter #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd), .req0_opnd(req0_opnd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd), .req1_opnd(req1_opnd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .alu_op(alu_op), .alu_form(alu_form), .alu_vec(alu_vec),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
        .alu_copy_neg(alu_copy_neg), .alu_copy_select(alu_copy_select),
        .alu_y1(alu_y1), .alu_y2(alu_y2), .busy(busy)
    );

    alu_arbiter #(.EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_cmd(b_req0_cmd), .req0_opnd(b_req0_opnd),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_cmd(b_req1_cmd), .req1_opnd(b_req1_opnd),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_y(b_rsp_y),
        .alu_op(b_alu_op), .alu_form(b_alu_form), .alu_vec(b_alu_vec),
        .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_c(b_alu_c), .alu_d(b_alu_d),
        .alu_copy_neg(b_alu_copy_neg), .alu_copy_select(b_alu_copy_select),
        .alu_y1(b_alu_y1), .alu_y2(b_alu_y2), .busy(b_busy)
    );

    // ALU stand-in: op0 -> {0, B*C}; op2 -> byte-masked (optionally inverted) A in Y1;
    // op4 -> form0 {A-C, 0}, form1 sign-extended A-C-D; others -> {A^B, C^D}.
    function automatic logic [63:0] alu_model(input logic [2:0] op, input logic form,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d,
                                              input logic neg, input logic [3:0] sel);
        logic [31:0] t, m, diff, diff2;
        t     = neg ? ~a : a;
        m     = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        diff  = a - c;
        diff2 = diff - d;
        case (op)
            3'd0:    return {32'd0, b * c};
            3'd2:    return {t & m, 32'd0};
            3'd4:    return form ? {{32{diff2[31]}}, diff2} : {diff, 32'd0};
            default: return {a ^ b, c ^ d};
        endcase
    endfunction

    always_comb {alu_y1, alu_y2} = alu_model(alu_op, alu_form, alu_a, alu_b, alu_c, alu_d,
                                             alu_copy_neg, alu_copy_select);
    always_comb {b_alu_y1, b_alu_y2} = alu_model(b_alu_op, b_alu_form, b_alu_a, b_alu_b, b_alu_c,
                                                 b_alu_d, b_alu_copy_neg, b_alu_copy_select);

    function automatic logic [10:0] mk_cmd(input logic [2:0] op, input logic form, input logic [1:0] vec,
                                           input logic neg, input logic [3:0] sel);
        return {op, form, vec, neg, sel};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_rsp(input int budget, input string tag);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            tick();
            n++;
        end
        if (!rsp_valid) check({tag, "_timeout"}, 64'(rsp_valid), 64'd1);
    endtask

    // Single-requester op on instance A: ready at t, rsp_valid visible two cycles later.
    task automatic run_single(input logic id, input logic [10:0] cmd, input logic [127:0] opnd,
                              input logic [63:0] exp_y, input string tag);
        if (id) begin
            req1_valid = 1'b1; req1_cmd = cmd; req1_opnd = opnd;
        end else begin
            req0_valid = 1'b1; req0_cmd = cmd; req0_opnd = opnd;
        end
        #1;
        check({tag, "_ready"}, 64'({req1_ready, req0_ready}), id ? 64'd2 : 64'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, "_busy"},   64'(busy), 64'd1);
        check({tag, "_early"},  64'(rsp_valid), 64'd0);
        check({tag, "_op"},     64'(alu_op), 64'(cmd[10:8]));
        check({tag, "_form"},   64'(alu_form), 64'(cmd[7]));
        check({tag, "_vec"},    64'(alu_vec), 64'(cmd[6:5]));
        check({tag, "_abcd"},   {alu_a ^ alu_b, alu_c ^ alu_d},
              {opnd[127:96] ^ opnd[95:64], opnd[63:32] ^ opnd[31:0]});
        check({tag, "_a"},      64'(alu_a), 64'(opnd[127:96]));
        tick();
        check({tag, "_valid"},  64'(rsp_valid), 64'd1);
        check({tag, "_y"},      rsp_y, exp_y);
        check({tag, "_id"},     64'(rsp_id), 64'(id));
        tick();
        check({tag, "_idle"},   64'({busy, rsp_valid}), 64'd0);
    endtask

    localparam logic [127:0] OPND  = {32'd1, 32'd2, 32'd3, 32'd2};
    localparam logic [63:0]  Y_ADD = 64'd6;
    localparam logic [63:0]  Y_SUB = 64'hFFFF_FFFE_0000_0000;
    localparam logic [63:0]  Y_NEG = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] c0, c1;
        int last_cyc;

        c0 = mk_cmd(3'd0, 1'b1, 2'd2, 1'b0, 4'd0);
        c1 = mk_cmd(3'd4, 1'b1, 2'd2, 1'b0, 4'd0);
        rst = 1'b1;
        req0_valid = 0; req0_cmd = '0; req0_opnd = '0;
        req1_valid = 0; req1_cmd = '0; req1_opnd = '0;
        rsp_ready = 1'b1;
        b_req0_valid = 0; b_req0_cmd = '0; b_req0_opnd = '0;
        b_req1_valid = 0; b_req1_cmd = '0; b_req1_opnd = '0;
        b_rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id",    64'(rsp_id), 64'd0);
        check("rst_rsp_y",     rsp_y, 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_alu_a",     64'(alu_a), 64'd0);
        check("rst_alu_d",     64'(alu_d), 64'd0);
        check("rst_alu_cmd",   64'({alu_op, alu_form, alu_vec, alu_copy_neg, alu_copy_select}), 64'd0);
        check("rst_readies",   64'({req1_ready, req0_ready}), 64'd0);
        rst = 1'b0;
        tick();

        // Lone requesters
        run_single(1'b0, mk_cmd(3'd0, 1'b1, 2'd2, 1'b0, 4'd0), OPND, Y_ADD, "r0");
        run_single(1'b1, mk_cmd(3'd4, 1'b0, 2'd2, 1'b0, 4'd0), OPND, Y_SUB, "r1");

        // Both valid through reset: reset beats the accepts, then grants alternate starting at req0
        rst = 1'b1;
        req0_valid = 1'b1; req0_cmd = c0; req0_opnd = OPND;
        req1_valid = 1'b1; req1_cmd = c1; req1_opnd = OPND;
        tick();
        tick();
        check("rst_vs_accept_busy", 64'(busy), 64'd0);
        check("rst_vs_accept_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(8, "alt");
            check("alt_id", 64'(rsp_id), 64'(k % 2));
            check("alt_y",  rsp_y, (k % 2) ? Y_NEG : Y_ADD);
            check("alt_readies_busy", 64'({req1_ready, req0_ready}), 64'd0);
            if (k > 0) check("alt_gap", 64'(cyc - last_cyc), 64'd3);
            last_cyc = cyc;
            tick();
        end

        // Backpressure: response held for five cycles, both readies low
        rsp_ready = 1'b0;
        wait_rsp(8, "bp");
        check("bp_id0", 64'(rsp_id), 64'd0);
        check("bp_y0",  rsp_y, Y_ADD);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid",   64'(rsp_valid), 64'd1);
            check("bp_y_hold",  rsp_y, Y_ADD);
            check("bp_id_hold", 64'(rsp_id), 64'd0);
            check("bp_readies", 64'({req1_ready, req0_ready}), 64'd0);
            check("bp_busy",    64'(busy), 64'd1);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release_idle", 64'({busy, rsp_valid}), 64'd0);
        check("bp_next_grant",   64'({req1_ready, req0_ready}), 64'd2);
        tick();
        check("bp_next_busy", 64'(busy), 64'd1);
        check("bp_next_op",   64'(alu_op), 64'd4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(8, "bp2");
        check("bp2_id", 64'(rsp_id), 64'd1);
        check("bp2_y",  rsp_y, Y_NEG);
        tick();

        // Reset during EXEC aborts the op; the next tie goes to req0 again
        req0_valid = 1'b1; req0_cmd = c0; req0_opnd = OPND;
        #1;
        check("mid_ready", 64'({req1_ready, req0_ready}), 64'd1);
        tick();
        req0_valid = 1'b0;
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy",  64'(busy), 64'd0);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_alu",   {alu_a, alu_b}, 64'd0);
        check("mid_rst_cmd",   64'({alu_op, alu_form, alu_vec}), 64'd0);
        tick();
        tick();
        check("mid_no_rsp", 64'(rsp_valid), 64'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("mid_tie_req0", 64'({req1_ready, req0_ready}), 64'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(8, "mid");
        check("mid_rsp_id", 64'(rsp_id), 64'd0);
        tick();

        // EXEC_CYCLES = 3: copy op with inverted A, byte 0 selected
        b_req0_valid = 1'b1;
        b_req0_cmd   = mk_cmd(3'b010, 1'b0, 2'd0, 1'b1, 4'b0001);
        b_req0_opnd  = {32'd3, 32'd0, 32'd0, 32'd0};
        #1;
        check("e3_ready", 64'({b_req1_ready, b_req0_ready}), 64'd1);
        tick();
        b_req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("e3_wait_valid", 64'(b_rsp_valid), 64'd0);
            check("e3_busy",       64'(b_busy), 64'd1);
            check("e3_alu_hold",   64'({b_alu_op, b_alu_form, b_alu_vec, b_alu_copy_neg, b_alu_copy_select}),
                  64'({3'b010, 1'b0, 2'd0, 1'b1, 4'b0001}));
            check("e3_opnd_hold",  64'({b_alu_a, b_alu_b ^ b_alu_c ^ b_alu_d}), 64'({32'd3, 32'd0}));
            tick();
        end
        check("e3_valid", 64'(b_rsp_valid), 64'd1);
        check("e3_y",     b_rsp_y, 64'h0000_00FC_0000_0000);
        check("e3_id",    64'(b_rsp_id), 64'd0);
        tick();
        check("e3_idle",  64'({b_busy, b_rsp_valid}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
